// File: rtl/i2c_master_read_burst.sv
// ---------------------------------------------------------------------------
// i2c_master_read_burst
//
// I2C master receive engine that reads 1..MAX_BYTES consecutive bytes from a
// slave inside a transaction that the controller above has already started
// and addressed. SCL timing is generated here: every bit lasts four phases of
// CLK_DIV clocks each, with SCL low in phases 0-1 and high in phases 2-3.
// SDA is sampled on the last clock of phase 2 and shifted in MSB first. After
// each byte the master ACKs, except after the final byte, which it NACKs.
// START/STOP and addressing belong to the transaction controller.
//
// Ports
//   clock       in   system clock, all logic on the rising edge
//   reset_n     in   synchronous active-low reset
//   go          in   level request, held high for the whole burst
//   byte_count  in   bytes to read (CW bits), sampled when leaving IDLE
//   data_out    out  last received byte
//   data_valid  out  one-cycle strobe, data_out holds a new byte
//   finish      out  burst complete, held until go drops
//   error       out  burst rejected or aborted, held until go drops
//   sda         in   SDA line sample
//   sda_oe      out  1 = pull SDA low, 0 = release
//   scl         out  SCL drive level
//   scl_in      in   SCL line sample (only with I2C_CLOCK_STRETCH_EN)
//
// Optional feature: define I2C_CLOCK_STRETCH_EN to honour slave clock
// stretching. The bit timer then waits at the start of phase 2 while scl_in
// is low; a wait longer than STRETCH_TIMEOUT clocks ends the burst in FAIL.
// In that build scl is the open-drain intent (1 = release high).
// ---------------------------------------------------------------------------
module i2c_master_read_burst #(
   parameter int CLK_DIV   = 4,
   parameter int MAX_BYTES = 4,
   parameter int CW        = $clog2(MAX_BYTES + 1)
`ifdef I2C_CLOCK_STRETCH_EN
   ,
   parameter int STRETCH_TIMEOUT = 1024
`endif
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          go,
   input  logic [CW-1:0] byte_count,
   output logic [7:0]    data_out,
   output logic          data_valid,
   output logic          finish,
   output logic          error,
   input  logic          sda,
`ifdef I2C_CLOCK_STRETCH_EN
   input  logic          scl_in,
`endif
   output logic          sda_oe,
   output logic          scl
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
   localparam logic [CW-1:0] COUNT_MAX = CW'(MAX_BYTES);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RX_BIT  = 3'd1,
      ACK_BIT = 3'd2,
      DONE    = 3'd3,
      FAIL    = 3'd4
   } state_t;

   state_t        state_r, state_s;
   logic [DW-1:0] div_r, div_s;
   logic [1:0]    phase_r, phase_s;
   logic [2:0]    bit_r, bit_s;
   logic [CW-1:0] left_r, left_s;
   logic [7:0]    shift_r, shift_s;
   logic          tick_s;
   logic          bit_end_s;
   logic          capture_s;
   logic          scl_s;
   logic          sda_oe_s;
   logic          hold_s;
   logic          timeout_s;

`ifdef I2C_CLOCK_STRETCH_EN
   // One extra count so that "held STRETCH_TIMEOUT clocks" is still representable.
   localparam int SW = $clog2(STRETCH_TIMEOUT + 2);
   logic [SW-1:0] stretch_r, stretch_s;

   // The slave stretches by keeping the line low once we have released it.
   assign hold_s    = ((state_r == RX_BIT) || (state_r == ACK_BIT)) &&
                      (phase_r == 2'd2) && (div_r == '0) && !scl_in;
   assign timeout_s = hold_s && (stretch_r == SW'(STRETCH_TIMEOUT));
   assign stretch_s = hold_s ? (stretch_r + SW'(1)) : '0;

   // Length of the current stretch.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         stretch_r <= '0;
      end else begin
         stretch_r <= stretch_s;
      end
   end
`else
   assign hold_s    = 1'b0;
   assign timeout_s = 1'b0;
`endif

   // Next-state, bit timing and shift register logic.
   always_comb begin
      state_s   = state_r;
      div_s     = div_r;
      phase_s   = phase_r;
      bit_s     = bit_r;
      left_s    = left_r;
      shift_s   = shift_r;
      capture_s = 1'b0;
      tick_s    = (div_r == DIV_LAST) && !hold_s;
      bit_end_s = tick_s && (phase_r == 2'd3);

      case (state_r)
         IDLE: begin
            div_s   = '0;
            phase_s = 2'd0;
            bit_s   = 3'd0;
            left_s  = '0;
            shift_s = 8'h00;
            if (go) begin
               if ((byte_count != '0) && (byte_count <= COUNT_MAX)) begin
                  left_s  = byte_count;
                  state_s = RX_BIT;
               end else begin
                  state_s = FAIL;
               end
            end else begin
               state_s = IDLE;
            end
         end

         RX_BIT, ACK_BIT: begin
            if (!go || timeout_s) begin
               // Abort or stretch timeout: drop the partial byte and all counts.
               state_s = go ? FAIL : IDLE;
               div_s   = '0;
               phase_s = 2'd0;
               bit_s   = 3'd0;
               left_s  = '0;
               shift_s = 8'h00;
            end else begin
               if (hold_s) begin
                  div_s = div_r;
               end else if (tick_s) begin
                  div_s   = '0;
                  phase_s = phase_r + 2'd1;
               end else begin
                  div_s = div_r + DW'(1);
               end

               if (state_r == RX_BIT) begin
                  if (tick_s && (phase_r == 2'd2)) begin
                     shift_s = {shift_r[6:0], sda};
                  end else begin
                     shift_s = shift_r;
                  end
                  if (bit_end_s) begin
                     if (bit_r == 3'd7) begin
                        bit_s     = 3'd0;
                        capture_s = 1'b1;
                        state_s   = ACK_BIT;
                     end else begin
                        bit_s = bit_r + 3'd1;
                     end
                  end else begin
                     bit_s = bit_r;
                  end
               end else begin
                  if (bit_end_s) begin
                     if (left_r > CW'(1)) begin
                        left_s  = left_r - CW'(1);
                        state_s = RX_BIT;
                     end else begin
                        left_s  = '0;
                        state_s = DONE;
                     end
                  end else begin
                     left_s = left_r;
                  end
               end
            end
         end

         DONE, FAIL: begin
            div_s   = '0;
            phase_s = 2'd0;
            bit_s   = 3'd0;
            left_s  = '0;
            if (!go) begin
               state_s = IDLE;
            end else begin
               state_s = state_r;
            end
         end

         default: begin
            state_s = IDLE;
            div_s   = '0;
            phase_s = 2'd0;
            bit_s   = 3'd0;
            left_s  = '0;
            shift_s = 8'h00;
         end
      endcase

      // Outputs are registered from the next state so they line up with it.
      scl_s    = ((state_s == RX_BIT) || (state_s == ACK_BIT)) && phase_s[1];
      // ACK while more bytes follow; the ACK slot of the last byte is a NACK.
      sda_oe_s = (state_s == ACK_BIT) && (left_s > CW'(1));
   end

   // State, counters and registered outputs.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         div_r      <= '0;
         phase_r    <= 2'd0;
         bit_r      <= 3'd0;
         left_r     <= '0;
         shift_r    <= 8'h00;
         scl        <= 1'b0;
         sda_oe     <= 1'b0;
         data_out   <= 8'h00;
         data_valid <= 1'b0;
         finish     <= 1'b0;
         error      <= 1'b0;
      end else begin
         state_r    <= state_s;
         div_r      <= div_s;
         phase_r    <= phase_s;
         bit_r      <= bit_s;
         left_r     <= left_s;
         shift_r    <= shift_s;
         scl        <= scl_s;
         sda_oe     <= sda_oe_s;
         data_out   <= capture_s ? shift_r : data_out;
         data_valid <= capture_s;
         finish     <= (state_s == DONE);
         error      <= (state_s == FAIL);
      end
   end

endmodule

// File: tb/tb_i2c_master_read_burst.sv
// ---------------------------------------------------------------------------
// Testbench for i2c_master_read_burst (CLK_DIV=2, MAX_BYTES=4).
// A behavioural slave presents bytes on SDA, advancing one bit per SCL fall.
// A timeline model derives every output from the cycle offset inside the
// burst; directed bursts add hand-computed expectations on top.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_master_read_burst;
   localparam int CLK_DIV   = 2;
   localparam int MAX_BYTES = 4;
   localparam int CW        = $clog2(MAX_BYTES + 1);
   localparam int BITP      = 4 * CLK_DIV;
   localparam int BYTEP     = 9 * BITP;
`ifdef I2C_CLOCK_STRETCH_EN
   localparam int STRETCH_TIMEOUT = 16;
`endif

   typedef enum int {M_IDLE, M_RUN, M_DONE, M_FAIL} mode_t;

   logic          clock      = 1'b0;
   logic          reset_n    = 1'b0;
   logic          go         = 1'b0;
   logic [CW-1:0] byte_count = '0;
   logic          slave_bit  = 1'b1;
   logic          hold       = 1'b0;
   logic          sda;
   logic [7:0]    data_out;
   logic          data_valid, finish, error, sda_oe, scl;

   assign sda = slave_bit & ~sda_oe;
`ifdef I2C_CLOCK_STRETCH_EN
   logic scl_in;
   assign scl_in = scl & ~hold;
`endif

   i2c_master_read_burst #(
      .CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES), .CW(CW)
`ifdef I2C_CLOCK_STRETCH_EN
      , .STRETCH_TIMEOUT(STRETCH_TIMEOUT)
`endif
   ) dut (
      .clock(clock), .reset_n(reset_n), .go(go), .byte_count(byte_count),
      .data_out(data_out), .data_valid(data_valid), .finish(finish),
      .error(error), .sda(sda),
`ifdef I2C_CLOCK_STRETCH_EN
      .scl_in(scl_in),
`endif
      .sda_oe(sda_oe), .scl(scl)
   );

   always #5 clock = ~clock;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc = 0;
   int         c0 = 0;
   mode_t      m_mode = M_IDLE;
   int         m_t = 0;
   int         m_n = 0;
   logic [7:0] m_data = 8'h00;
   bit         model_en = 1'b0;
   logic [7:0] slave_bytes [MAX_BYTES];
   int         slave_fall = 0;
   logic       scl_prev = 1'b0;
   logic       scl_iprev = 1'b0;
   int         dv_at[$];
   logic [7:0] dv_val[$];
   logic       dv_oe[$];
   int         dv_base = 0;
   int         fin_at = -1;
   int         err_at = -1;
   logic       fin_prev = 1'b0;
   logic       err_prev = 1'b0;
   int         scl_rises = 0;
   bit         stretch_req = 1'b0;
   int         stretch_len = 0;
   int         hold_left = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected outputs from the position inside the burst timeline.
   task automatic compare_outputs();
      int u, k, r, b, ph;
      logic e_scl, e_oe, e_dv;
      e_scl = 1'b0; e_oe = 1'b0; e_dv = 1'b0;
      if (m_mode == M_RUN) begin
         u  = m_t - 1;
         k  = u / BYTEP;
         r  = u % BYTEP;
         b  = r / BITP;
         ph = (r % BITP) / CLK_DIV;
         e_scl = (ph >= 2);
         if (b == 8) begin
            e_oe = (k < m_n - 1);
            e_dv = ((r % BITP) == 0);
         end
      end
      check("scl", scl, e_scl);
      check("sda_oe", sda_oe, e_oe);
      check("data_valid", data_valid, e_dv);
      check("data_out", data_out, m_data);
      check("finish", finish, m_mode == M_DONE);
      check("error", error, m_mode == M_FAIL);
   endtask

   task automatic model_update();
      if (!reset_n) begin
         m_mode = M_IDLE; m_t = 0; m_data = 8'h00;
      end else begin
         case (m_mode)
            M_IDLE: if (go) begin
               if (byte_count >= 1 && byte_count <= MAX_BYTES) begin
                  m_mode = M_RUN; m_n = int'(byte_count); m_t = 1;
               end else begin
                  m_mode = M_FAIL;
               end
            end
            M_RUN: if (!go) begin
               m_mode = M_IDLE; m_t = 0;
            end else if (m_t == m_n * BYTEP) begin
               m_mode = M_DONE;
            end else begin
               m_t++;
               if (((m_t - 1) % BYTEP) == 8 * BITP) m_data = slave_bytes[(m_t - 1) / BYTEP];
            end
            default: if (!go) m_mode = M_IDLE;
         endcase
      end
   endtask

   // One clock: observe and check at negedge, slave reacts, model follows the edge.
   task automatic tick();
      int bi, bp;
      logic line;
      @(negedge clock);
      if (model_en) compare_outputs();
      if (data_valid) begin
         dv_at.push_back(cyc - c0); dv_val.push_back(data_out); dv_oe.push_back(sda_oe);
      end
      if (finish && !fin_prev) fin_at = cyc - c0;
      if (error && !err_prev) err_at = cyc - c0;
      fin_prev = finish; err_prev = error;
      if (scl && !scl_iprev) scl_rises++;
      line = scl & ~hold;
      if (!go || !reset_n) slave_fall = 0;
      else if (scl_prev && !line) slave_fall++;
      if (hold) begin
         hold_left--;
         if (hold_left == 0) hold = 1'b0;
      end else if (stretch_req && scl && !scl_iprev) begin
         hold = 1'b1; hold_left = stretch_len; stretch_req = 1'b0;
      end
      scl_iprev = scl;
      scl_prev  = scl & ~hold;
      bi = slave_fall / 9;
      bp = slave_fall % 9;
      if (bp == 8 || bi >= MAX_BYTES) slave_bit = 1'b1;
      else slave_bit = slave_bytes[bi][7 - bp];
      @(posedge clock);
      cyc++;
      model_update();
      #2;
   endtask

   task automatic arm();
      c0 = cyc; dv_base = dv_at.size(); fin_at = -1; err_at = -1;
   endtask

   task automatic start_burst(input int n);
      byte_count = CW'(n); go = 1'b1; arm();
   endtask

   task automatic wait_finish(input int budget);
      int cnt;
      cnt = 0;
      while (fin_at < 0 && err_at < 0 && cnt < budget) begin tick(); cnt++; end
      check("finish_seen", fin_at >= 0, 1'b1);
   endtask

   task automatic end_burst();
      go = 1'b0; tick(); tick(); tick();
   endtask

   initial begin
      int r0;
      for (int i = 0; i < MAX_BYTES; i++) slave_bytes[i] = 8'h00;
      tick();
      model_en = 1'b1;
      tick();
      reset_n = 1'b1;
      tick();
      check("rst_scl", scl, 1'b0);
      check("rst_data_out", data_out, 8'h00);
      check("rst_error", error, 1'b0);

      // One byte, NACKed.
      slave_bytes[0] = 8'hA5;
      start_burst(1);
      wait_finish(BYTEP + 20);
      check("b1_dv_count", dv_at.size() - dv_base, 1);
      check("b1_dv_cycle", dv_at[dv_base], 65);
      check("b1_dv_data", dv_val[dv_base], 8'hA5);
      check("b1_nack", dv_oe[dv_base], 1'b0);
      check("b1_finish_cycle", fin_at, 73);
      repeat (4) tick();
      check("b1_finish_held", finish, 1'b1);
      end_burst();
      check("b1_finish_clear", finish, 1'b0);

      // Three bytes: ACK, ACK, NACK.
      slave_bytes[0] = 8'h12; slave_bytes[1] = 8'h34; slave_bytes[2] = 8'h56;
      start_burst(3);
      wait_finish(3 * BYTEP + 20);
      check("b3_dv_count", dv_at.size() - dv_base, 3);
      check("b3_dv0", dv_at[dv_base], 65);
      check("b3_dv1", dv_at[dv_base + 1], 137);
      check("b3_dv2", dv_at[dv_base + 2], 209);
      check("b3_data0", dv_val[dv_base], 8'h12);
      check("b3_data1", dv_val[dv_base + 1], 8'h34);
      check("b3_data2", dv_val[dv_base + 2], 8'h56);
      check("b3_ack0", dv_oe[dv_base], 1'b1);
      check("b3_ack1", dv_oe[dv_base + 1], 1'b1);
      check("b3_nack2", dv_oe[dv_base + 2], 1'b0);
      check("b3_finish_cycle", fin_at, 217);
      end_burst();

      // Bad counts: zero and above MAX_BYTES.
      for (int n = 0; n <= MAX_BYTES + 1; n += MAX_BYTES + 1) begin
         r0 = scl_rises;
         start_burst(n);
         repeat (5) tick();
         check("bad_err_cycle", err_at, 1);
         check("bad_no_scl", scl_rises, r0);
         go = 1'b0;
         tick();
         tick();
         check("bad_err_clear", error, 1'b0);
      end

      // Abort at cycle 40, then a clean burst.
      slave_bytes[0] = 8'h9C; slave_bytes[1] = 8'h3B;
      start_burst(2);
      while (cyc - c0 < 40) tick();
      go = 1'b0;
      repeat (4) tick();
      check("abort_scl", scl, 1'b0);
      check("abort_oe", sda_oe, 1'b0);
      check("abort_no_dv", dv_at.size() - dv_base, 0);
      check("abort_no_finish", fin_at, -1);
      slave_bytes[0] = 8'h5A;
      start_burst(1);
      wait_finish(BYTEP + 20);
      check("restart_dv_cycle", dv_at[dv_base], 65);
      check("restart_data", dv_val[dv_base], 8'h5A);
      check("restart_finish", fin_at, 73);
      end_burst();

      // Reset during an ACK bit, go held high, then a fresh burst.
      slave_bytes[0] = 8'h11; slave_bytes[1] = 8'h22;
      start_burst(2);
      while (cyc - c0 < 68) tick();
      check("ack_before_reset", sda_oe, 1'b1);
      reset_n = 1'b0; slave_bytes[0] = 8'hFF; byte_count = CW'(1);
      tick();
      check("rst_mid_oe", sda_oe, 1'b0);
      check("rst_mid_data", data_out, 8'h00);
      check("rst_mid_scl", scl, 1'b0);
      reset_n = 1'b1;
      arm();
      wait_finish(BYTEP + 20);
      check("post_rst_dv_cycle", dv_at[dv_base], 65);
      check("post_rst_data", dv_val[dv_base], 8'hFF);
      check("post_rst_finish", fin_at, 73);
      end_burst();

`ifdef I2C_CLOCK_STRETCH_EN
      // Stretch of 10 clocks shifts the byte by 10; 20 clocks times out.
      model_en = 1'b0;
      slave_bytes[0] = 8'hA5;
      stretch_req = 1'b1; stretch_len = 10;
      start_burst(1);
      wait_finish(BYTEP + 40);
      check("st_dv_cycle", dv_at[dv_base], 75);
      check("st_data", dv_val[dv_base], 8'hA5);
      check("st_finish", fin_at, 83);
      end_burst();
      stretch_req = 1'b1; stretch_len = 20;
      start_burst(1);
      for (int i = 0; i < 60 && err_at < 0; i++) tick();
      check("st_timeout_err", err_at, 22);
      end_burst();
      repeat (20) tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
